// File: rtl/collision_matrix_arbiter.sv
// collision_matrix_arbiter
// Per-pixel collision detector for N_SRC movers against N_TGT targets.
// Hits are accumulated into a sticky matrix over one frame. At each frame
// boundary the matrix is frozen into a snapshot that is streamed out as
// (src,tgt) events over a valid/ready port, one pair examined per cycle.
// A per-source flag produces one hit pulse per source per frame.

module collision_matrix_arbiter #(
  parameter int N_SRC = 4,
  parameter int N_TGT = 16,
  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int TW = (N_TGT > 1) ? $clog2(N_TGT) : 1,
  localparam int CW = $clog2(N_SRC * N_TGT + 1)
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startOfFrame,
  input  logic [N_SRC-1:0] dr_src,
  input  logic [N_TGT-1:0] dr_tgt,
  input  logic [N_TGT-1:0] tgt_enable,
  output logic             collision,
  output logic [N_SRC-1:0] src_hit_pulse,
  output logic             evt_valid,
  output logic [SW-1:0]    evt_src,
  output logic [TW-1:0]    evt_tgt,
  input  logic             evt_ready,
  output logic [CW-1:0]    hit_count,
  output logic             overrun
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  logic [N_SRC-1:0][N_TGT-1:0] pair_hit;
  logic [N_SRC-1:0][N_TGT-1:0] acc;
  logic [N_SRC-1:0][N_TGT-1:0] snap;
  logic [N_SRC-1:0]            src_any;
  logic [N_SRC-1:0]            src_flag;
  logic [N_SRC-1:0]            flag_base;
  logic [CW-1:0]               acc_count;

  state_t          state, state_next;
  logic [SW-1:0]   ptr_src, ptr_src_next;
  logic [TW-1:0]   ptr_tgt, ptr_tgt_next;
  logic            evt_valid_next;
  logic [SW-1:0]   evt_src_next;
  logic [TW-1:0]   evt_tgt_next;
  logic            overrun_next;
  logic            last_pair;
  logic            advance;

  // Pair hits for this pixel: a source overlapping an enabled target.
  always_comb begin
    pair_hit = '0;
    src_any  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      pair_hit[i] = {N_TGT{dr_src[i]}} & dr_tgt & tgt_enable;
      src_any[i]  = |pair_hit[i];
    end
  end

  assign collision = |pair_hit;

  // Population count of the accumulator, used for hit_count and to decide whether to scan.
  always_comb begin
    acc_count = '0;
    for (int i = 0; i < N_SRC; i++) begin
      for (int j = 0; j < N_TGT; j++) begin
        acc_count = acc_count + CW'(acc[i][j]);
      end
    end
  end

  // Sticky accumulator; at frame start it is frozen into the snapshot and restarts with this pixel's hits.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc       <= '0;
      snap      <= '0;
      hit_count <= '0;
    end else if (startOfFrame) begin
      snap      <= acc;
      acc       <= pair_hit;
      hit_count <= acc_count;
    end else begin
      acc <= acc | pair_hit;
    end
  end

  // At frame start the flags are treated as already cleared, so a hit in that cycle still pulses.
  assign flag_base = startOfFrame ? '0 : src_flag;

  // One pulse per source per frame, on the cycle after its first hit.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      src_flag      <= '0;
      src_hit_pulse <= '0;
    end else begin
      src_flag      <= flag_base | src_any;
      src_hit_pulse <= src_any & ~flag_base;
    end
  end

  // Scanner state and event output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      ptr_src   <= '0;
      ptr_tgt   <= '0;
      evt_valid <= 1'b0;
      evt_src   <= '0;
      evt_tgt   <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_next;
      ptr_src   <= ptr_src_next;
      ptr_tgt   <= ptr_tgt_next;
      evt_valid <= evt_valid_next;
      evt_src   <= evt_src_next;
      evt_tgt   <= evt_tgt_next;
      overrun   <= overrun_next;
    end
  end

  assign last_pair = (ptr_src == SW'(N_SRC - 1)) && (ptr_tgt == TW'(N_TGT - 1));

  // Snapshot walk in src-major order; a frame start always wins and restarts the walk.
  always_comb begin
    state_next     = state;
    ptr_src_next   = ptr_src;
    ptr_tgt_next   = ptr_tgt;
    evt_valid_next = evt_valid;
    evt_src_next   = evt_src;
    evt_tgt_next   = evt_tgt;
    overrun_next   = 1'b0;
    advance        = 1'b0;

    if (startOfFrame) begin
      overrun_next   = (state == SCAN);
      evt_valid_next = 1'b0;
      ptr_src_next   = '0;
      ptr_tgt_next   = '0;
      state_next     = (acc_count != '0) ? SCAN : IDLE;
    end else begin
      case (state)
        IDLE: begin
          evt_valid_next = 1'b0;
        end
        SCAN: begin
          if (evt_valid) begin
            if (evt_ready) begin
              evt_valid_next = 1'b0;
              advance        = 1'b1;
            end
          end else if (snap[ptr_src][ptr_tgt]) begin
            evt_valid_next = 1'b1;
            evt_src_next   = ptr_src;
            evt_tgt_next   = ptr_tgt;
          end else begin
            advance = 1'b1;
          end
        end
        default: begin
          state_next     = IDLE;
          evt_valid_next = 1'b0;
        end
      endcase

      if (advance) begin
        if (last_pair) begin
          state_next   = IDLE;
          ptr_src_next = '0;
          ptr_tgt_next = '0;
        end else if (ptr_tgt == TW'(N_TGT - 1)) begin
          ptr_tgt_next = '0;
          ptr_src_next = ptr_src + 1'b1;
        end else begin
          ptr_tgt_next = ptr_tgt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_collision_matrix_arbiter.sv
// tb_collision_matrix_arbiter
// Directed bench for the collision matrix arbiter: pixel hits, pulses,
// frame snapshots, event streaming with back-pressure, overrun and reset.

module tb_collision_matrix_arbiter;

  localparam int N_SRC = 4;
  localparam int N_TGT = 16;
  localparam int SW    = 2;
  localparam int TW    = 4;
  localparam int CW    = 7;

  logic             clk;
  logic             resetN;
  logic             startOfFrame;
  logic [N_SRC-1:0] dr_src;
  logic [N_TGT-1:0] dr_tgt;
  logic [N_TGT-1:0] tgt_enable;
  logic             collision;
  logic [N_SRC-1:0] src_hit_pulse;
  logic             evt_valid;
  logic [SW-1:0]    evt_src;
  logic [TW-1:0]    evt_tgt;
  logic             evt_ready;
  logic [CW-1:0]    hit_count;
  logic             overrun;

  int checks;
  int errors;
  int got_ev [0:127];
  int got_n;

  collision_matrix_arbiter #(.N_SRC(N_SRC), .N_TGT(N_TGT)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .dr_src        (dr_src),
    .dr_tgt        (dr_tgt),
    .tgt_enable    (tgt_enable),
    .collision     (collision),
    .src_hit_pulse (src_hit_pulse),
    .evt_valid     (evt_valid),
    .evt_src       (evt_src),
    .evt_tgt       (evt_tgt),
    .evt_ready     (evt_ready),
    .hit_count     (hit_count),
    .overrun       (overrun)
  );

  // Free-running pixel clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one pixel's inputs and let the combinational path settle.
  task automatic applyStimulus(input logic [N_SRC-1:0] src, input logic [N_TGT-1:0] tgt, input logic sof);
    dr_src       = src;
    dr_tgt       = tgt;
    startOfFrame = sof;
    #1;
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ev(input int s, input int t);
    return s * N_TGT + t;
  endfunction

  // Accept every event for a fixed number of cycles, recording them in order.
  task automatic drainEvents(input int maxCycles);
    got_n = 0;
    evt_ready = 1'b1;
    applyStimulus('0, '0, 1'b0);
    for (int c = 0; c < maxCycles; c++) begin
      if (evt_valid && got_n < 128) begin
        got_ev[got_n] = int'({evt_src, evt_tgt});
        got_n++;
      end
      step();
    end
    evt_ready = 1'b0;
  endtask

  // Bounded wait for an event to become valid.
  task automatic waitValid(input string tag, input int maxCycles);
    for (int c = 0; c < maxCycles && !evt_valid; c++) step();
    checkOutput(tag, 32'(evt_valid), 32'd1);
  endtask

  // Directed scenarios.
  initial begin
    checks       = 0;
    errors       = 0;
    got_n        = 0;
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    dr_src       = '0;
    dr_tgt       = '0;
    tgt_enable   = '1;
    evt_ready    = 1'b0;
    step();
    step();
    checkOutput("rst_valid", 32'(evt_valid), 32'd0);
    checkOutput("rst_count", 32'(hit_count), 32'd0);
    checkOutput("rst_pulse", 32'(src_hit_pulse), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    resetN = 1'b1;
    step();

    // 1: src0 over tgt5 for three pixels.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0001, 16'h0020, 1'b0);
      checkOutput("t1_coll", 32'(collision), 32'd1);
      step();
      checkOutput("t1_pulse", 32'(src_hit_pulse), (k == 0) ? 32'd1 : 32'd0);
    end
    applyStimulus('0, '0, 1'b0);
    checkOutput("t1_nocoll", 32'(collision), 32'd0);
    step();
    applyStimulus('0, '0, 1'b1);
    step();
    checkOutput("t1_count", 32'(hit_count), 32'd1);
    drainEvents(80);
    checkOutput("t1_nev", 32'(got_n), 32'd1);
    checkOutput("t1_ev0", 32'(got_ev[0]), 32'(ev(0, 5)));

    // 2: three hits streamed in src-major order with ready held high.
    applyStimulus(4'b0001, 16'h0204, 1'b0);
    step();
    checkOutput("t2_pulse0", 32'(src_hit_pulse), 32'h1);
    applyStimulus(4'b1000, 16'h0001, 1'b0);
    step();
    checkOutput("t2_pulse3", 32'(src_hit_pulse), 32'h8);
    applyStimulus('0, '0, 1'b1);
    step();
    checkOutput("t2_count", 32'(hit_count), 32'd3);
    drainEvents(80);
    checkOutput("t2_nev", 32'(got_n), 32'd3);
    checkOutput("t2_ev0", 32'(got_ev[0]), 32'(ev(0, 2)));
    checkOutput("t2_ev1", 32'(got_ev[1]), 32'(ev(0, 9)));
    checkOutput("t2_ev2", 32'(got_ev[2]), 32'(ev(3, 0)));

    // 3: same hits, consumer stalls for ten cycles.
    applyStimulus(4'b0001, 16'h0204, 1'b0);
    step();
    applyStimulus(4'b1000, 16'h0001, 1'b0);
    step();
    applyStimulus('0, '0, 1'b1);
    step();
    applyStimulus('0, '0, 1'b0);
    waitValid("t3_wait", 20);
    for (int k = 0; k < 10; k++) begin
      checkOutput("t3_hold", 32'({evt_valid, evt_src, evt_tgt}), 32'({1'b1, 2'd0, 4'd2}));
      step();
    end
    drainEvents(80);
    checkOutput("t3_nev", 32'(got_n), 32'd3);
    checkOutput("t3_ev0", 32'(got_ev[0]), 32'(ev(0, 2)));
    checkOutput("t3_ev1", 32'(got_ev[1]), 32'(ev(0, 9)));
    checkOutput("t3_ev2", 32'(got_ev[2]), 32'(ev(3, 0)));

    // 4: disabled target is ignored entirely.
    tgt_enable = 16'hFFDF;
    applyStimulus(4'b0001, 16'h0020, 1'b0);
    checkOutput("t4_coll", 32'(collision), 32'd0);
    step();
    checkOutput("t4_pulse", 32'(src_hit_pulse), 32'd0);
    applyStimulus('0, '0, 1'b1);
    step();
    checkOutput("t4_count", 32'(hit_count), 32'd0);
    drainEvents(80);
    checkOutput("t4_nev", 32'(got_n), 32'd0);
    tgt_enable = '1;

    // 5: eight pending events overrun by a frame carrying a single new hit.
    applyStimulus(4'b0001, 16'h00FF, 1'b0);
    step();
    applyStimulus('0, '0, 1'b1);
    step();
    checkOutput("t5_count8", 32'(hit_count), 32'd8);
    applyStimulus('0, '0, 1'b0);
    waitValid("t5_wait", 20);
    step();
    step();
    checkOutput("t5_noover", 32'(overrun), 32'd0);
    applyStimulus(4'b0010, 16'h0008, 1'b0);
    step();
    applyStimulus('0, '0, 1'b1);
    step();
    checkOutput("t5_overrun", 32'(overrun), 32'd1);
    checkOutput("t5_valid0", 32'(evt_valid), 32'd0);
    checkOutput("t5_count1", 32'(hit_count), 32'd1);
    applyStimulus('0, '0, 1'b0);
    step();
    checkOutput("t5_overpulse", 32'(overrun), 32'd0);
    drainEvents(80);
    checkOutput("t5_nev", 32'(got_n), 32'd1);
    checkOutput("t5_ev0", 32'(got_ev[0]), 32'(ev(1, 3)));

    // 6: hit coinciding with frame start belongs to the new frame.
    applyStimulus(4'b0100, 16'h0080, 1'b1);
    checkOutput("t6_coll", 32'(collision), 32'd1);
    step();
    checkOutput("t6_pulse", 32'(src_hit_pulse), 32'h4);
    checkOutput("t6_count0", 32'(hit_count), 32'd0);
    applyStimulus(4'b0100, 16'h0080, 1'b0);
    step();
    checkOutput("t6_nopulse", 32'(src_hit_pulse), 32'd0);
    applyStimulus('0, '0, 1'b1);
    step();
    checkOutput("t6_count1", 32'(hit_count), 32'd1);
    drainEvents(80);
    checkOutput("t6_nev", 32'(got_n), 32'd1);
    checkOutput("t6_ev0", 32'(got_ev[0]), 32'(ev(2, 7)));

    // 6b: asynchronous reset in the middle of a drain.
    applyStimulus(4'b0001, 16'h00FF, 1'b0);
    step();
    applyStimulus('0, '0, 1'b1);
    step();
    applyStimulus('0, '0, 1'b0);
    checkOutput("t6r_count8", 32'(hit_count), 32'd8);
    waitValid("t6r_wait", 20);
    resetN = 1'b0;
    #1;
    checkOutput("t6r_valid", 32'(evt_valid), 32'd0);
    checkOutput("t6r_count", 32'(hit_count), 32'd0);
    step();
    resetN = 1'b1;
    applyStimulus('0, '0, 1'b1);
    step();
    checkOutput("t6r_count_after", 32'(hit_count), 32'd0);
    drainEvents(80);
    checkOutput("t6r_nev", 32'(got_n), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
